// File: rtl/haz_scoreboard_if.sv
// Decode-stage hazard interface: D-stage instruction fields, long-op completion,
// redirect request, and the resulting stall/flush/forward controls.
interface haz_scoreboard_if #(
  parameter int AW = 5,
  parameter int CW = 16
);
  logic          d_valid;
  logic [AW-1:0] d_addr1;
  logic [AW-1:0] d_addr2;
  logic          d_use1;
  logic          d_use2;
  logic [AW-1:0] d_waddr;
  logic          d_wen;
  logic [1:0]    d_lat;
  logic          d_long;
  logic          long_done;
  logic [AW-1:0] long_waddr;
  logic          redirect;
  logic          stall;
  logic          flush;
  logic [1:0]    fwd_rs1;
  logic [1:0]    fwd_rs2;
  logic [CW-1:0] stall_cnt;

  // Pipeline control side: presents D-stage info, consumes hazard decisions.
  modport master (
    output d_valid, d_addr1, d_addr2, d_use1, d_use2, d_waddr, d_wen,
           d_lat, d_long, long_done, long_waddr, redirect,
    input  stall, flush, fwd_rs1, fwd_rs2, stall_cnt
  );

  // Scoreboard side.
  modport slave (
    input  d_valid, d_addr1, d_addr2, d_use1, d_use2, d_waddr, d_wen,
           d_lat, d_long, long_done, long_waddr, redirect,
    output stall, flush, fwd_rs1, fwd_rs2, stall_cnt
  );
endinterface

// File: rtl/haz_scoreboard.sv
// Per-register hazard scoreboard for the 5-stage pipeline. Each architectural
// register tracks whether a write is in flight, how far it has travelled
// (age 1=E, 2=M, 3=W), the stage at which its result becomes forwardable,
// and whether it is a long-latency write retired by handshake.
// Stall, flush and forward selects are combinational from the D-stage
// inputs and the registered scoreboard.
module haz_scoreboard #(
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int FWD_EN = 1,
  parameter int CW     = 16
) (
  input logic           clk,
  input logic           rst,
  haz_scoreboard_if.slave sb_if
);

  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] long_r;
  logic [1:0]      age_r [NREG];
  logic [1:0]      lat_r [NREG];
  logic [CW-1:0]   stall_cnt_r;

  logic [AW-1:0]   addr1_s;
  logic [AW-1:0]   addr2_s;
  logic [AW-1:0]   waddr_s;
  logic [AW-1:0]   lwaddr_s;
  logic            done1_s;
  logic            done2_s;
  logic            donew_s;
  logic [2:0]      chk1_s;
  logic [2:0]      chk2_s;
  logic            waw_s;
  logic            stall_s;
  logic            flush_s;
  logic            issue_s;

  // Per-operand check: returns {hazard, forward select}. A long entry is only
  // readable in the cycle its result appears at W; a short entry forwards from
  // the stage it currently occupies once it has reached its result stage.
  function automatic logic [2:0] src_check(
    input logic       use_s,
    input logic       nz_s,
    input logic       busy_s,
    input logic       long_s,
    input logic [1:0] age_s,
    input logic [1:0] lat_s,
    input logic       done_s
  );
    logic       hz;
    logic [1:0] fwd;
    hz  = 1'b0;
    fwd = 2'b00;
    if (use_s && nz_s) begin
      if (FWD_EN != 0) begin
        if (busy_s) begin
          if (long_s) begin
            if (done_s) begin
              fwd = 2'b11;
            end else begin
              hz = 1'b1;
            end
          end else begin
            if (age_s < lat_s) begin
              hz = 1'b1;
            end else begin
              fwd = age_s;
            end
          end
        end else begin
          fwd = 2'b00;
        end
      end else begin
        hz = busy_s;
      end
    end else begin
      hz = 1'b0;
    end
    return {hz, fwd};
  endfunction

  assign addr1_s  = sb_if.d_addr1;
  assign addr2_s  = sb_if.d_addr2;
  assign waddr_s  = sb_if.d_waddr;
  assign lwaddr_s = sb_if.long_waddr;
  assign done1_s  = sb_if.long_done && (lwaddr_s == addr1_s);
  assign done2_s  = sb_if.long_done && (lwaddr_s == addr2_s);
  assign donew_s  = sb_if.long_done && (lwaddr_s == waddr_s);

  // Hazard detection, WAW against pending long writes, and stall/flush/issue.
  always_comb begin
    chk1_s = src_check(sb_if.d_use1, addr1_s != {AW{1'b0}}, busy_r[addr1_s],
                       long_r[addr1_s], age_r[addr1_s], lat_r[addr1_s], done1_s);
    chk2_s = src_check(sb_if.d_use2, addr2_s != {AW{1'b0}}, busy_r[addr2_s],
                       long_r[addr2_s], age_r[addr2_s], lat_r[addr2_s], done2_s);
    waw_s  = sb_if.d_wen && (waddr_s != {AW{1'b0}}) && busy_r[waddr_s] &&
             long_r[waddr_s] && !donew_s;
    stall_s = sb_if.d_valid && !sb_if.redirect && (chk1_s[2] || chk2_s[2] || waw_s);
    flush_s = sb_if.redirect;
    issue_s = sb_if.d_valid && sb_if.d_wen && (waddr_s != {AW{1'b0}}) &&
              !stall_s && !flush_s;
  end

  assign sb_if.stall     = stall_s;
  assign sb_if.flush     = flush_s;
  assign sb_if.fwd_rs1   = (FWD_EN != 0) ? chk1_s[1:0] : 2'b00;
  assign sb_if.fwd_rs2   = (FWD_EN != 0) ? chk2_s[1:0] : 2'b00;
  assign sb_if.stall_cnt = stall_cnt_r;

  // Scoreboard update: new issue wins, then long completion, then aging.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= {NREG{1'b0}};
      long_r <= {NREG{1'b0}};
      for (int r = 0; r < NREG; r++) begin
        age_r[r] <= 2'b00;
        lat_r[r] <= 2'b00;
      end
    end else begin
      busy_r[0] <= 1'b0;
      long_r[0] <= 1'b0;
      age_r[0]  <= 2'b00;
      lat_r[0]  <= 2'b00;
      for (int r = 1; r < NREG; r++) begin
        if (issue_s && (waddr_s == AW'(r))) begin
          busy_r[r] <= 1'b1;
          long_r[r] <= sb_if.d_long;
          age_r[r]  <= 2'b01;
          lat_r[r]  <= sb_if.d_lat;
        end else if (busy_r[r] && long_r[r]) begin
          if (sb_if.long_done && (lwaddr_s == AW'(r))) begin
            busy_r[r] <= 1'b0;
            long_r[r] <= 1'b0;
            age_r[r]  <= 2'b00;
            lat_r[r]  <= 2'b00;
          end
        end else if (busy_r[r]) begin
          if (age_r[r] == 2'b11) begin
            busy_r[r] <= 1'b0;
            age_r[r]  <= 2'b00;
            lat_r[r]  <= 2'b00;
          end else begin
            age_r[r] <= age_r[r] + 2'b01;
          end
        end
      end
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CW{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CW{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule
